// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Sequential instruction fetch with a 2-entry {pc, instr} queue,
//               EBREAK-triggered halt and priority redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [31:0] ALIGN_MASK = ~32'h0000_0003;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [31:0] pc_buf_q    [2];
  logic [31:0] instr_buf_q [2];

  logic        pop;
  logic        push;
  logic        tail;

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = pc_buf_q[head_q];
  assign out_instr = instr_buf_q[head_q];
  assign halted    = (state_q == ST_HALTED);

  // With two slots the tail is head+count mod 2; when full it aliases the
  // head, which is exactly the slot freed by a same-cycle pop.
  assign tail = head_q ^ count_q[0];
  assign pop  = out_valid && out_ready;
  assign push = (state_q == ST_RUN) && !redirect_valid &&
                ((count_q != 2'd2) || pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    if (redirect_valid) begin
      state_d = ST_RUN;
      pc_d    = redirect_pc & ALIGN_MASK;
      count_d = 2'd0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      head_d  = head_q ^ pop;
      if (push) begin
        pc_d = pc_q + 32'd4;
        if (imem_instr == HALT_INSTR) begin
          state_d = ST_HALTED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC & ALIGN_MASK;
      count_q <= 2'd0;
      head_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  // Payload is qualified by count, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_buf_q[tail]    <= pc_q;
      instr_buf_q[tail] <= imem_instr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  logic        halt_en;
  int          n_cmp;
  int          n_err;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: NOP everywhere, optionally EBREAK at 0xC.
  assign imem_instr = (halt_en && imem_addr == 32'h0000_000C) ? 32'h0010_0073
                                                              : 32'h0000_0013;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt_en        = 1'b0;

    // Reset state visible before any clock edge
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);

    // Streaming
    step();
    rst_n = 1'b1;
    check("str_pre_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("str_valid0", {31'd0, out_valid}, 32'd1);
    check("str_pc0", out_pc, 32'h0);
    check("str_instr0", out_instr, 32'h0000_0013);
    check("str_addr0", imem_addr, 32'h4);
    step();
    check("str_pc1", out_pc, 32'h4);
    step();
    check("str_pc2", out_pc, 32'h8);
    check("str_addr2", imem_addr, 32'hC);

    // Backpressure
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_pc", out_pc, 32'h0);
    check("bp_addr", imem_addr, 32'h8);
    out_ready = 1'b1;
    check("bp_rel_pc0", out_pc, 32'h0);
    step();
    check("bp_rel_pc1", out_pc, 32'h4);
    check("bp_rel_addr", imem_addr, 32'hC);
    step();
    check("bp_rel_pc2", out_pc, 32'h8);

    // Redirect with a full queue
    out_ready = 1'b0;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    check("rd_preflush_valid", {31'd0, out_valid}, 32'd1);
    step();
    redirect_valid = 1'b0;
    check("rd_flush_valid", {31'd0, out_valid}, 32'd0);
    check("rd_addr", imem_addr, 32'h100);
    step();
    check("rd_valid", {31'd0, out_valid}, 32'd1);
    check("rd_pc", out_pc, 32'h100);

    // Halt on EBREAK at 0xC
    out_ready = 1'b1;
    halt_en   = 1'b1;
    do_reset();
    step();
    check("h_pc0", out_pc, 32'h0);
    step();
    check("h_pc4", out_pc, 32'h4);
    step();
    check("h_pc8", out_pc, 32'h8);
    check("h_not_yet", {31'd0, halted}, 32'd0);
    step();
    check("h_pcC", out_pc, 32'hC);
    check("h_instrC", out_instr, 32'h0010_0073);
    check("h_halted", {31'd0, halted}, 32'd1);
    check("h_addr", imem_addr, 32'h10);
    step();
    check("h_drained", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("h_hold_addr", imem_addr, 32'h10);
    check("h_hold_halted", {31'd0, halted}, 32'd1);
    check("h_hold_valid", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("h_resume_halted", {31'd0, halted}, 32'd0);
    check("h_resume_addr", imem_addr, 32'h40);
    step();
    check("h_resume_pc", out_pc, 32'h40);

    // Asynchronous reset mid-stream with a full queue
    out_ready = 1'b0;
    step();
    step();
    check("ar_full_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_addr", imem_addr, 32'h0);
    check("ar_halted", {31'd0, halted}, 32'd0);

    // PC wrap
    halt_en = 1'b0;
    step();
    rst_n          = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("w_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("w_pc_top", out_pc, 32'hFFFF_FFFC);
    check("w_addr_wrap", imem_addr, 32'h0);
    step();
    check("w_pc_zero", out_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, fetch address loaded at reset.
REQ-002 Parameter HALT_INSTR, 32'h0010_0073 (EBREAK), instruction word that stops fetching.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_addr  output  32  fetch address driven to the instruction memory; equals the internal PC.
REQ-006 imem_instr  input  32  instruction word returned combinationally, in the same cycle, for imem_addr.
REQ-007 out_valid  output  1  head entry of the fetch queue is valid.
REQ-008 out_ready  input  1  downstream decode accepts the head entry this cycle.
REQ-009 out_instr  output  32  instruction word of the head entry.
REQ-010 out_pc  output  32  fetch address of the head entry.
REQ-011 redirect_valid  input  1  branch/jump/trap redirect request.
REQ-012 redirect_pc  input  32  redirect target address.
REQ-013 halted  output  1  unit is in the HALTED state.

Function
REQ-014 PC register: 32 bits, always word-aligned, with bits [1:0] held at 0.
REQ-015 Fetch queue: 2-entry FIFO of {pc, instr} pairs with an occupancy count of 0..2 and a head pointer that wraps modulo 2.
REQ-016 FSM states: RUN and HALTED.
REQ-017 Fetch condition: state is RUN, redirect_valid is 0, and either count < 2 or a pop occurs in the same cycle.
REQ-018 On a fetch, the unit pushes {PC, imem_instr} at the tail and sets PC <= PC + 4, with the 32-bit add wrapping from 32'hFFFF_FFFC to 0.
REQ-019 Pop condition: out_valid and out_ready are both 1; the head advances by one entry.
REQ-020 On a simultaneous push and pop with count=2, count stays 2 and the popped slot is reused; with count=1, count stays 1.
REQ-021 out_valid = (count != 0); out_instr and out_pc come combinationally from the head entry and remain stable while out_valid=1 and out_ready=0.
REQ-022 When the pushed imem_instr equals HALT_INSTR, the entry is still enqueued and the state moves RUN -> HALTED on that edge; PC advances by 4 as normal.
REQ-023 In HALTED, no fetches occur, PC holds, queued entries continue to drain through the handshake, and halted = 1.
REQ-024 Redirect has priority over all other activity:
  - on an edge where redirect_valid=1, the queue is flushed (count <= 0) and any pop that cycle is discarded;
  - PC <= {redirect_pc[31:2], 2'b00};
  - state <= RUN, from either state;
  - no push occurs that cycle.
REQ-025 Outputs in a cycle where redirect_valid=1 still reflect pre-flush state; the redirect takes effect from the next cycle.
REQ-026 Fetch latency: an instruction at PC appears on out_instr one cycle after imem_addr=PC, provided the queue was empty.
REQ-027 Sustained throughput with out_ready held at 1 is one instruction per cycle.

Reset
REQ-028 While rst_n=0:
  - PC = RESET_PC, count = 0, head = 0, state = RUN;
  - out_valid = 0, halted = 0, imem_addr = RESET_PC;
  - all of the above take effect immediately, without waiting for a clk edge.
REQ-029 Queue payload registers need not be reset; out_instr and out_pc are don't-care while out_valid=0.
REQ-030 Deassertion of rst_n takes effect on the next edge. The first fetch occurs on the first rising clk edge with rst_n=1.
REQ-031 Asserting reset mid-operation discards all queued entries and any HALTED state.

Verification
REQ-032 Streaming, with out_ready=1 and memory words 0x00000013 at every address from reset: out_pc sequence 0x0, 0x4, 0x8, ... with one entry per cycle, starting one cycle after reset release.
REQ-033 Backpressure, with out_ready=0 for 5 cycles: count saturates at 2, imem_addr holds at 0x8, and out_pc holds 0x0; on raising out_ready, out_pc delivers 0x0, 0x4, 0x8 in consecutive cycles.
REQ-034 Redirect with a full queue, redirect_pc=0x0000_0103: the next cycle has out_valid=0 and imem_addr=0x100; the cycle after has out_pc=0x100.
REQ-035 Halt, with the word at 0xC equal to 0x0010_0073: the entries at 0x0..0xC are delivered, halted=1, and imem_addr holds at 0x10 indefinitely; redirect_pc=0x40 clears halted and fetching resumes at 0x40.
REQ-036 Reset mid-stream, with rst_n driven low between clock edges while count=2: out_valid=0 and imem_addr=RESET_PC immediately, with no clock edge required.
REQ-037 PC wrap, with a redirect to 0xFFFF_FFFC: out_pc delivers 0xFFFF_FFFC followed by 0x0000_0000.
